// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, a single held instruction, redirect handling.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] w_nextPc;
  logic        r_drop;
  logic        w_nextDrop;
  logic [31:0] r_inst;
  logic [31:0] r_instPc;
  logic        w_capture;
  logic        w_reqHs;
  logic [31:0] w_redirPc;

`ifdef IFU_MISALIGN_CHECK_EN
  logic w_misaligned;
  assign w_redirPc    = redirect_pc;
  assign w_misaligned = |redirect_pc[1:0];
  assign fetch_err    = (r_state == S_ERR);
`else
  assign w_redirPc = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_err = 1'b0;
`endif

  assign w_reqHs        = (r_state == S_REQ) && imem_req_ready;
  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == S_HOLD);
  assign inst           = r_inst;
  assign inst_pc        = r_instPc;

  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_nextDrop  = r_drop;
    w_capture   = 1'b0;

    case (r_state)
      S_IDLE: w_nextState = S_REQ;
      S_REQ: begin
        if (w_reqHs) w_nextState = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (r_drop) begin
            w_nextDrop  = 1'b0;
            w_nextState = S_REQ;
          end else begin
            w_capture   = 1'b1;
            w_nextState = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          w_nextPc    = r_pc + 32'd4;
          w_nextState = S_REQ;
        end
      end
      default: w_nextState = r_state;
    endcase

    // A redirect overrides everything; a request still in flight after this edge must be dropped.
    // If its response lands in the redirect cycle itself, it is simply discarded here.
    if (redirect_valid && (r_state != S_ERR)) begin
`ifdef IFU_MISALIGN_CHECK_EN
      if (w_misaligned) begin
        w_nextState = S_ERR;
        w_nextDrop  = 1'b0;
        w_nextPc    = r_pc;
        w_capture   = 1'b0;
      end else begin
`else
      begin
`endif
        w_nextPc  = w_redirPc;
        w_capture = 1'b0;
        if (w_reqHs || ((r_state == S_WAIT) && !imem_resp_valid)) begin
          w_nextDrop  = 1'b1;
          w_nextState = S_WAIT;
        end else begin
          w_nextDrop  = 1'b0;
          w_nextState = S_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_drop   <= 1'b0;
      r_inst   <= 32'd0;
      r_instPc <= 32'd0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      r_drop  <= w_nextDrop;
      if (w_capture) begin
        r_inst   <= imem_resp_data;
        r_instPc <= r_pc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        respValid;
    logic [31:0] respData;
    logic        instReady;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        expReqValid;
    logic [31:0] expAddr;
    logic        expInstValid;
    logic [31:0] expInst;
    logic [31:0] expInstPc;
  } vec_t;

  vec_t vecs[$];

  // Reference model: fetch progress described as request/response bookkeeping.
  logic        mStarted, mOut, mDiscard, mHeld, mErr;
  logic [31:0] mPc, mInst, mInstPc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkState(input string tag, input logic eReqV, input logic [31:0] eAddr,
                            input logic eInstV, input logic [31:0] eInst, input logic [31:0] ePc,
                            input logic eErr);
    checkOutput({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, eReqV});
    if (eReqV) checkOutput({tag, ".req_addr"}, imem_req_addr, eAddr);
    checkOutput({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, eInstV});
    if (eInstV) begin
      checkOutput({tag, ".inst"}, inst, eInst);
      checkOutput({tag, ".inst_pc"}, inst_pc, ePc);
    end
    checkOutput({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, eErr});
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic dv, input logic [31:0] dpc);
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    inst_ready      = ir;
    redirect_valid  = dv;
    redirect_pc     = dpc;
  endtask

  task automatic addVec(input logic rdy, input logic rv, input logic [31:0] rd, input logic ir,
                        input logic dv, input logic [31:0] dpc, input logic eReqV,
                        input logic [31:0] eAddr, input logic eInstV, input logic [31:0] eInst,
                        input logic [31:0] ePc);
    vec_t v;
    v.ready = rdy; v.respValid = rv; v.respData = rd; v.instReady = ir;
    v.redirValid = dv; v.redirPc = dpc; v.expReqValid = eReqV; v.expAddr = eAddr;
    v.expInstValid = eInstV; v.expInst = eInst; v.expInstPc = ePc;
    vecs.push_back(v);
  endtask

  // Leaves the bench at a falling edge with reset just released (cycle 0).
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic modelReset();
    mStarted = 1'b0; mOut = 1'b0; mDiscard = 1'b0; mHeld = 1'b0; mErr = 1'b0;
    mPc = 32'h8000_0000; mInst = 32'd0; mInstPc = 32'd0;
  endtask

  function automatic logic modelReqValid();
    return mStarted && !mOut && !mHeld && !mErr;
  endfunction

  task automatic modelStep(input logic rdy, input logic rv, input logic [31:0] rd,
                           input logic ir, input logic dv, input logic [31:0] dpc,
                           output logic hs);
    logic [31:0] target;
    hs = modelReqValid() && rdy;
    if (mErr) begin
      hs = 1'b0;
    end else if (dv) begin
`ifdef IFU_MISALIGN_CHECK_EN
      target = dpc;
      if (dpc[1:0] != 2'b00) begin
        mErr  = 1'b1;
        mHeld = 1'b0;
        return;
      end
`else
      target = {dpc[31:2], 2'b00};
`endif
      mPc      = target;
      mHeld    = 1'b0;
      mStarted = 1'b1;
      mOut     = hs || (mOut && !rv);
      mDiscard = mOut;
    end else if (!mStarted) begin
      mStarted = 1'b1;
    end else if (hs) begin
      mOut = 1'b1;
    end else if (mOut && rv) begin
      mOut = 1'b0;
      if (mDiscard) mDiscard = 1'b0;
      else begin
        mHeld   = 1'b1;
        mInst   = rd;
        mInstPc = mPc;
      end
    end else if (mHeld && ir) begin
      mHeld = 1'b0;
      mPc   = mPc + 32'd4;
    end
  endtask

  initial begin
    // Directed table, one row per cycle starting at cycle 0 after reset release.
    //      rdy rv  data           ir  dv  redirect       eReqV eAddr          eInstV eInst          ePc
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0000, 0, 32'h0,          32'h0);
    addVec(1, 1, 32'h0000_0013,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0013,  32'h8000_0000);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0004, 0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          0, 1, 32'h8000_0100, 0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8000_0100, 0, 32'h0,          32'h0);
    addVec(1, 1, 32'h0000_1111,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_1111,  32'h8000_0100);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_1111,  32'h8000_0100);
    addVec(1, 1, 32'hFFFF_FFFF,  0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_1111,  32'h8000_0100);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_1111,  32'h8000_0100);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_1111,  32'h8000_0100);
    addVec(1, 0, 32'h0,          1, 1, 32'h8000_0200, 0, 32'h0,          1, 32'h0000_1111,  32'h8000_0100);
    addVec(0, 1, 32'h7777_7777,  0, 0, 32'h0,          1, 32'h8000_0200, 0, 32'h0,          32'h0);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0200, 0, 32'h0,          32'h0);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0200, 0, 32'h0,          32'h0);
    addVec(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0200, 0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0200, 0, 32'h0,          32'h0);
    addVec(1, 1, 32'h0000_2222,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          1, 32'h0000_2222,  32'h8000_0200);
    addVec(0, 0, 32'h0,          0, 1, 32'h8000_0300, 1, 32'h8000_0204, 0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          0, 1, 32'h8000_0400, 1, 32'h8000_0300, 0, 32'h0,          32'h0);
    addVec(1, 1, 32'h0000_3333,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8000_0400, 0, 32'h0,          32'h0);
    addVec(1, 1, 32'h0000_4444,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          1, 32'h0000_4444,  32'h8000_0400);
    addVec(0, 0, 32'h0,          0, 1, 32'hFFFF_FFFC, 1, 32'h8000_0404, 0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0);
    addVec(1, 1, 32'h0000_5555,  0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    addVec(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          1, 32'h0000_5555,  32'hFFFF_FFFC);
    addVec(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          32'h0);

    // Reset values while reset is held.
    #1;
    checkState("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("reset.inst", inst, 32'd0);
    checkOutput("reset.inst_pc", inst_pc, 32'd0);

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      checkState($sformatf("vec%0d", i), vecs[i].expReqValid, vecs[i].expAddr,
                 vecs[i].expInstValid, vecs[i].expInst, vecs[i].expInstPc, 1'b0);
      applyStimulus(vecs[i].ready, vecs[i].respValid, vecs[i].respData, vecs[i].instReady,
                    vecs[i].redirValid, vecs[i].redirPc);
      @(negedge clk);
    end

    // Table ends with a handshake at address 0, so the unit is now waiting on memory.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    checkState("rstWait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("rstWait.inst", inst, 32'd0);
    checkOutput("rstWait.inst_pc", inst_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkState("lateResp1", 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkState("lateResp2", 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 1'b0);

    // Misaligned redirect while requesting.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0102);
    @(negedge clk);
`ifdef IFU_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      checkState($sformatf("misalign%0d", i), 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h8000_0200);
      @(negedge clk);
    end
`else
    checkState("misalign", 1'b1, 32'h8000_0100, 1'b0, 32'h0, 32'h0, 1'b0);
`endif

    // Randomized traffic against the reference model.
    begin
      int          pend;
      logic        rdy, rv, ir, dv, hs;
      logic [31:0] rd, dpc;
      doReset();
      modelReset();
      pend = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        checkState($sformatf("rand%0d", cyc), modelReqValid(), mPc, mHeld && !mErr,
                   mInst, mInstPc, mErr);
        rdy = ($urandom_range(0, 3) != 0);
        ir  = ($urandom_range(0, 1) == 1);
        rd  = $urandom();
        rv  = (pend == 1);
        if (pend != 0) pend--;
        else if (!mOut && $urandom_range(0, 7) == 0) rv = 1'b1;
        dv  = ($urandom_range(0, 11) == 0);
        dpc = $urandom();
        if ($urandom_range(0, 15) != 0) dpc[1:0] = 2'b00;
        applyStimulus(rdy, rv, rd, ir, dv, dpc);
        modelStep(rdy, rv, rd, ir, dv, dpc, hs);
        if (hs) pend = $urandom_range(1, 3);
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
